// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// uart_rx_pkg : shared parity modes, FSM states and limits for the UART receiver
// Revision    : 1.0
// ============================================================================
package uart_rx_pkg;

   localparam int MIN_PRESCALE  = 4;
   localparam int MIN_DATA_BITS = 5;

   typedef enum logic [1:0] {
      PAR_EVEN  = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_MARK  = 2'b10,
      PAR_SPACE = 2'b11
   } par_mode_e;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_START  = 3'd1;
   localparam state_t ST_DATA   = 3'd2;
   localparam state_t ST_PARITY = 3'd3;
   localparam state_t ST_STOP   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_rx_bit_sampler.sv
`default_nettype none
// ============================================================================
// uart_rx_bit_sampler : per-bit oversampling counter with 2-of-3 majority vote
// Revision            : 1.0
// ============================================================================
module uart_rx_bit_sampler #(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  rx,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  bit_done,
   output logic                  bit_val
);

   localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] cnt;
   logic [PRESCALE_W-1:0] half;
   logic                  samp_a;
   logic                  samp_b;

   assign half = prescale >> 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         samp_a <= 1'b0;
         samp_b <= 1'b0;
      end else begin
         // The start cycle itself is count 0 of the start bit.
         if (start) begin
            cnt <= ONE;
         end else if (cnt == prescale - ONE) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + ONE;
         end
         if (cnt == half - ONE) samp_a <= rx;
         if (cnt == half)       samp_b <= rx;
      end
   end

   assign bit_done = (cnt == half + ONE);
   assign bit_val  = (samp_a & samp_b) | (samp_a & rx) | (samp_b & rx);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame_engine.sv
`default_nettype none
// ============================================================================
// uart_rx_frame_engine : synchronised, oversampled UART frame receiver with valid/ready output
// Revision             : 1.0
// ============================================================================
module uart_rx_frame_engine
   import uart_rx_pkg::*;
#(
   parameter int DATA_W_MAX  = 9,
   parameter int PRESCALE_W  = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] cfg_prescale,
   input  logic [3:0]            cfg_data_bits,
   input  logic                  cfg_par_en,
   input  logic [1:0]            cfg_par_typ,
   input  logic                  cfg_stop2,
   output logic [DATA_W_MAX-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_parity_err,
   output logic                  o_frame_err,
   output logic                  o_break,
   output logic                  o_start_err,
   output logic                  o_overrun,
   output logic                  o_busy
);

   localparam logic [PRESCALE_W-1:0] PRE_MIN = PRESCALE_W'(MIN_PRESCALE);
   localparam logic [3:0]            DB_MIN  = 4'(MIN_DATA_BITS);
   localparam logic [3:0]            DB_MAX  = 4'(DATA_W_MAX);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic                   rx_prev;
   logic                   fall;
   logic                   start;

   state_t                  state;
   logic [PRESCALE_W-1:0]   presc_q;
   logic [3:0]              nbits_q;
   logic                    par_en_q;
   par_mode_e               par_q;
   logic                    stop2_q;
   logic [3:0]              bit_idx;
   logic                    stop_idx;
   logic [DATA_W_MAX-1:0]   shreg;
   logic                    all_zero;
   logic                    par_err_q;
   logic                    frm_err_q;
   logic                    brk_q;
   logic                    par_exp;

   logic bit_done;
   logic bit_val;
   logic frame_done;
   logic fin_frm;
   logic fin_brk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '1;
         rx_prev <= 1'b1;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_in};
         rx_prev <= rx_s;
      end
   end

   assign rx_s  = sync_q[SYNC_STAGES-1];
   assign fall  = rx_prev & ~rx_s;
   assign start = enable & (state == ST_IDLE) & fall;

   uart_rx_bit_sampler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_sampler (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rx       (rx_s),
      .prescale (presc_q),
      .bit_done (bit_done),
      .bit_val  (bit_val)
   );

   always_comb begin
      par_exp = 1'b0;
      case (par_q)
         PAR_EVEN: par_exp = ^shreg;
         PAR_ODD:  par_exp = ~^shreg;
         PAR_MARK: par_exp = 1'b1;
         default:  par_exp = 1'b0;
      endcase
   end

   // Final-stop decision: flags are resolved combinationally so the output loads one cycle later.
   assign frame_done = enable & (state == ST_STOP) & bit_done & (stop_idx | ~stop2_q);
   assign fin_frm    = (stop_idx & frm_err_q) | ~bit_val;
   assign fin_brk    = stop_idx ? brk_q : (all_zero & ~bit_val);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         presc_q     <= PRE_MIN;
         nbits_q     <= DB_MIN;
         par_en_q    <= 1'b0;
         par_q       <= PAR_EVEN;
         stop2_q     <= 1'b0;
         bit_idx     <= '0;
         stop_idx    <= 1'b0;
         shreg       <= '0;
         all_zero    <= 1'b0;
         par_err_q   <= 1'b0;
         frm_err_q   <= 1'b0;
         brk_q       <= 1'b0;
         o_start_err <= 1'b0;
      end else begin
         o_start_err <= 1'b0;
         if (!enable) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (fall) begin
                     state     <= ST_START;
                     presc_q   <= (cfg_prescale < PRE_MIN) ? PRE_MIN : cfg_prescale;
                     nbits_q   <= (cfg_data_bits < DB_MIN) ? DB_MIN :
                                  (cfg_data_bits > DB_MAX) ? DB_MAX : cfg_data_bits;
                     par_en_q  <= cfg_par_en;
                     par_q     <= par_mode_e'(cfg_par_typ);
                     stop2_q   <= cfg_stop2;
                     bit_idx   <= '0;
                     stop_idx  <= 1'b0;
                     shreg     <= '0;
                     all_zero  <= 1'b1;
                     par_err_q <= 1'b0;
                     frm_err_q <= 1'b0;
                     brk_q     <= 1'b0;
                  end
               end
               ST_START: begin
                  if (bit_done) begin
                     if (bit_val) begin
                        o_start_err <= 1'b1;
                        state       <= ST_IDLE;
                     end else begin
                        state <= ST_DATA;
                     end
                  end
               end
               ST_DATA: begin
                  if (bit_done) begin
                     for (int i = 0; i < DATA_W_MAX; i++) begin
                        if (i == int'(bit_idx)) shreg[i] <= bit_val;
                     end
                     all_zero <= all_zero & ~bit_val;
                     if (bit_idx == nbits_q - 4'd1) begin
                        state <= par_en_q ? ST_PARITY : ST_STOP;
                     end else begin
                        bit_idx <= bit_idx + 4'd1;
                     end
                  end
               end
               ST_PARITY: begin
                  if (bit_done) begin
                     par_err_q <= (bit_val != par_exp);
                     all_zero  <= all_zero & ~bit_val;
                     state     <= ST_STOP;
                  end
               end
               ST_STOP: begin
                  if (bit_done) begin
                     if (!stop_idx) begin
                        frm_err_q <= ~bit_val;
                        brk_q     <= all_zero & ~bit_val;
                        if (stop2_q) stop_idx <= 1'b1;
                        else         state    <= ST_IDLE;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_break      <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         if (frame_done && (!o_valid || i_ready)) begin
            o_data       <= fin_brk ? '0 : shreg;
            o_valid      <= 1'b1;
            o_parity_err <= par_err_q;
            o_frame_err  <= fin_frm;
            o_break      <= fin_brk;
         end else if (frame_done) begin
            o_overrun <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

   assign o_busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_engine.sv
`default_nettype none
// tb_uart_rx_frame_engine : directed and randomized frames checked against a frame-level model.
module tb_uart_rx_frame_engine;

   localparam int DW = 9;
   localparam int PW = 6;
   localparam int SS = 2;

   typedef struct {
      logic [8:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
      int         lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b1;
   logic          rx_in = 1'b1;
   logic [PW-1:0] cfg_prescale = 6'd8;
   logic [3:0]    cfg_data_bits = 4'd8;
   logic          cfg_par_en = 1'b0;
   logic [1:0]    cfg_par_typ = 2'd0;
   logic          cfg_stop2 = 1'b0;
   logic          i_ready = 1'b1;
   logic [DW-1:0] o_data;
   logic          o_valid, o_parity_err, o_frame_err, o_break, o_start_err, o_overrun, o_busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rises = 0, serrs = 0, ovrs = 0;
   int rise_cyc = 0, serr_cyc = 0, ovr_cyc = 0;
   logic [8:0] rise_data = '0;
   logic rise_perr = 1'b0, rise_ferr = 1'b0, rise_brk = 1'b0;
   logic vprev = 1'b0;
   logic line_q[$];

   always #5 clk = ~clk;

   uart_rx_frame_engine #(
      .DATA_W_MAX  (DW),
      .PRESCALE_W  (PW),
      .SYNC_STAGES (SS)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .rx_in         (rx_in),
      .cfg_prescale  (cfg_prescale),
      .cfg_data_bits (cfg_data_bits),
      .cfg_par_en    (cfg_par_en),
      .cfg_par_typ   (cfg_par_typ),
      .cfg_stop2     (cfg_stop2),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_parity_err  (o_parity_err),
      .o_frame_err   (o_frame_err),
      .o_break       (o_break),
      .o_start_err   (o_start_err),
      .o_overrun     (o_overrun),
      .o_busy        (o_busy)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      vprev <= o_valid;
      if (o_valid && !vprev) begin
         rises     <= rises + 1;
         rise_cyc  <= cyc;
         rise_data <= o_data;
         rise_perr <= o_parity_err;
         rise_ferr <= o_frame_err;
         rise_brk  <= o_break;
      end
      if (o_start_err) begin
         serrs    <= serrs + 1;
         serr_cyc <= cyc;
      end
      if (o_overrun) begin
         ovrs    <= ovrs + 1;
         ovr_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Line bits and expected outcome of one frame, derived from the frame format rules.
   task automatic build_frame(input logic [8:0] d, input int nb, input logic pen, input logic [1:0] pt,
                              input logic s2, input logic flip_par, input logic bad_stop, input int p,
                              input logic clr, input int gap, output exp_t e);
      int mask, f;
      logic [8:0] dm;
      logic pexp, psent, st_first, st_last;
      mask = (1 << nb) - 1;
      dm = d & mask[8:0];
      case (pt)
         2'd0:    pexp = ^dm;
         2'd1:    pexp = ~^dm;
         2'd2:    pexp = 1'b1;
         default: pexp = 1'b0;
      endcase
      psent    = pexp ^ flip_par;
      st_first = s2 ? 1'b1 : ~bad_stop;
      st_last  = ~bad_stop;
      if (clr) line_q.delete();
      line_q.push_back(1'b0);
      for (int i = 0; i < nb; i++) line_q.push_back(dm[i]);
      if (pen) line_q.push_back(psent);
      line_q.push_back(st_first);
      if (s2) line_q.push_back(st_last);
      for (int i = 0; i < gap; i++) line_q.push_back(1'b1);
      e.brk  = (dm == 9'd0) && (!pen || !psent) && !st_first;
      e.data = e.brk ? 9'd0 : dm;
      e.perr = pen && (psent != pexp);
      e.ferr = !st_first || (s2 && !st_last);
      f = 1 + nb + (pen ? 1 : 0) + (s2 ? 2 : 1);
      e.lat = (f - 1) * p + p / 2 + 2;
   endtask

   // Each queued bit is held for p clocks; t0 is the cycle in which the synchronised fall is visible.
   task automatic drive_line(input int p, input logic scramble, output int t0);
      t0 = cyc + SS;
      for (int i = 0; i < line_q.size(); i++) begin
         rx_in = line_q[i];
         repeat (p) @(posedge clk);
         #1;
         if (scramble && i == 0) begin
            cfg_prescale  = PW'($urandom);
            cfg_data_bits = 4'($urandom);
            cfg_par_en    = 1'($urandom);
            cfg_par_typ   = 2'($urandom);
            cfg_stop2     = 1'($urandom);
         end
      end
      rx_in = 1'b1;
   endtask

   task automatic check_frame(input string tag, input int t0, input exp_t e, input int rb);
      chk({tag, "_count"}, rises, rb + 1);
      chk({tag, "_latency"}, rise_cyc, t0 + e.lat);
      chk({tag, "_data"}, rise_data, e.data);
      chk({tag, "_perr"}, rise_perr, e.perr);
      chk({tag, "_ferr"}, rise_ferr, e.ferr);
      chk({tag, "_brk"}, rise_brk, e.brk);
   endtask

   task automatic set_cfg(input int p, input int nb, input logic pen, input logic [1:0] pt, input logic s2);
      cfg_prescale  = PW'(p);
      cfg_data_bits = 4'(nb);
      cfg_par_en    = pen;
      cfg_par_typ   = pt;
      cfg_stop2     = s2;
   endtask

   initial begin
      exp_t e, e2;
      int t0, rb, sb, ob;
      int rp, rnb, pe, ne;
      logic [8:0] d;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_flags", {o_parity_err, o_frame_err, o_break, o_start_err, o_overrun}, 0);
      chk("rst_busy", o_busy, 0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_busy", o_busy, 0);

      // 8N1 at P=8
      set_cfg(8, 8, 1'b0, 2'd0, 1'b0);
      rb = rises;
      build_frame(9'h0A5, 8, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 2, e);
      chk("t1_model_lat", e.lat, 78);
      drive_line(8, 1'b0, t0);
      check_frame("t1", t0, e, rb);

      // 7E2 at P=16 with a wrong parity bit
      set_cfg(16, 7, 1'b1, 2'd0, 1'b1);
      rb = rises;
      build_frame(9'h035, 7, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 16, 1'b1, 2, e);
      drive_line(16, 1'b0, t0);
      check_frame("t2", t0, e, rb);

      // 5-clock glitch at P=16
      rb = rises;
      sb = serrs;
      line_q.delete();
      line_q.push_back(1'b0);
      for (int i = 0; i < 7; i++) line_q.push_back(1'b1);
      drive_line(5, 1'b0, t0);
      chk("t3_serr_count", serrs, sb + 1);
      chk("t3_serr_cycle", serr_cyc, t0 + 10);
      chk("t3_no_valid", rises, rb);
      chk("t3_busy", o_busy, 0);

      // back-to-back frames with the consumer stalled
      set_cfg(8, 8, 1'b0, 2'd0, 1'b0);
      i_ready = 1'b0;
      rb = rises;
      ob = ovrs;
      build_frame(9'h011, 8, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 0, e);
      build_frame(9'h022, 8, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 2, e2);
      drive_line(8, 1'b0, t0);
      check_frame("t4a", t0, e, rb);
      chk("t4_ovr_count", ovrs, ob + 1);
      chk("t4_ovr_cycle", ovr_cyc, t0 + 80 + e2.lat);
      chk("t4_valid_held", o_valid, 1);
      chk("t4_data_held", o_data, 9'h011);
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t4_valid_fall", o_valid, 0);
      chk("t4_data_kept", o_data, 9'h011);

      // break: line low for 12 bit times, 8O1
      set_cfg(8, 8, 1'b1, 2'd1, 1'b0);
      rb = rises;
      line_q.delete();
      for (int i = 0; i < 12; i++) line_q.push_back(1'b0);
      line_q.push_back(1'b1);
      line_q.push_back(1'b1);
      e.data = 9'd0;
      e.perr = 1'b1;
      e.ferr = 1'b1;
      e.brk  = 1'b1;
      e.lat  = 10 * 8 + 4 + 2;
      drive_line(8, 1'b0, t0);
      check_frame("t5", t0, e, rb);

      // prescale below minimum, 9-bit mark parity
      set_cfg(2, 9, 1'b1, 2'd2, 1'b0);
      rb = rises;
      build_frame(9'h1FF, 9, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4, 1'b1, 2, e);
      drive_line(4, 1'b0, t0);
      check_frame("t6", t0, e, rb);

      // abort mid-frame with enable
      rb = rises;
      sb = serrs;
      build_frame(9'h0AB, 9, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4, 1'b1, 0, e);
      while (line_q.size() > 5) void'(line_q.pop_back());
      drive_line(4, 1'b0, t0);
      chk("t7_busy_mid", o_busy, 1);
      enable = 1'b0;
      @(posedge clk);
      #1;
      chk("t7_busy_abort", o_busy, 0);
      repeat (60) @(posedge clk);
      #1;
      chk("t7_no_valid", rises, rb);
      chk("t7_no_serr", serrs, sb);
      chk("t7_flags", {o_start_err, o_overrun}, 0);
      enable = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // randomized frames with cfg scrambled after the start bit
      for (int n = 0; n < 12; n++) begin
         rp  = $urandom_range(0, 12);
         rnb = $urandom_range(0, 15);
         pe  = (rp < 4) ? 4 : rp;
         ne  = (rnb < 5) ? 5 : ((rnb > 9) ? 9 : rnb);
         d   = 9'($urandom);
         if ($urandom_range(0, 5) == 0) d = 9'd0;
         set_cfg(rp, rnb, 1'($urandom), 2'($urandom), 1'($urandom));
         rb = rises;
         build_frame(d, ne, cfg_par_en, cfg_par_typ, cfg_stop2, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), pe, 1'b1, 2, e);
         drive_line(pe, 1'b1, t0);
         check_frame($sformatf("rnd%0d", n), t0, e, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
